// File: rtl/inst_queue_pkg.sv
// Shared definitions for the fetch-to-decode instruction queue.
// Entry layout and the empty-slot filler used by inst_queue and its storage.
package inst_queue_pkg;

  localparam int INST_QUEUE_DEPTH = 4;
  localparam int IQ_DATA_W        = 64;
  localparam int IQ_ECODE_W       = 6;

  typedef struct packed {
    logic [IQ_DATA_W-1:0]  data;
    logic                  exc;
    logic [IQ_ECODE_W-1:0] ecode;
  } IQ_ENTRY;

  localparam IQ_ENTRY IQ_NOP = '{data: '0, exc: 1'b0, ecode: '0};

endpackage

// File: rtl/iq_ram.sv
// Entry storage for inst_queue: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; occupancy tracking lives in the parent.
module iq_ram #(
  parameter int DEPTH = 4,
  parameter int W     = 71,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_queue.sv
// Elastic IF->ID buffer: valid/allow handshake in and out, intake frozen after an
// exception entry, cleared by flush. Optional zero-latency path: INST_QUEUE_BYPASS_EN.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH   = INST_QUEUE_DEPTH,
  parameter int DATA_W  = IQ_DATA_W,
  parameter int ECODE_W = IQ_ECODE_W
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       valid_in,
  input  logic [DATA_W-1:0]          data_in,
  input  logic                       exc_in,
  input  logic [ECODE_W-1:0]         ecode_in,
  output logic                       allow_out,
  output logic                       valid_out,
  output logic [DATA_W-1:0]          data_out,
  output logic                       exc_out,
  output logic [ECODE_W-1:0]         ecode_out,
  input  logic                       allow_in,
  input  logic [DATA_W-1:0]          nop_data,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = DATA_W + 1 + ECODE_W;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic               exc;
    logic [ECODE_W-1:0] ecode;
  } entry_t;

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          exc_lock;
  logic          has_head;
  logic          bypass;
  logic          push;
  logic          pop;
  logic          wr_en;
  logic          rd_en;
  entry_t        wr_entry;
  entry_t        head;

  assign wr_entry = '{data: data_in, exc: exc_in, ecode: ecode_in};

  // allow_out depends only on registered state, never on allow_in.
  assign has_head  = (count != '0);
  assign allow_out = (count != FULL_CNT) && !exc_lock;

`ifdef INST_QUEUE_BYPASS_EN
  assign bypass = !has_head && valid_in && !exc_lock;
`else
  assign bypass = 1'b0;
`endif

  assign valid_out = has_head || bypass;
  assign push      = valid_in && allow_out;
  assign pop       = valid_out && allow_in;
  // A bypassed entry taken by ID the same cycle never touches storage.
  assign wr_en     = push && !(bypass && allow_in);
  assign rd_en     = pop && has_head;

  iq_ram #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_ram (
    .clk   (aclk),
    .we    (wr_en && !flush),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (head)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      exc_lock <= 1'b0;
    end else if (flush) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      exc_lock <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (push && exc_in) exc_lock <= 1'b1;
    end
  end

  always_comb begin
    data_out  = nop_data;
    exc_out   = 1'b0;
    ecode_out = '0;
    if (has_head) begin
      data_out  = head.data;
      exc_out   = head.exc;
      ecode_out = head.ecode;
    end else if (bypass) begin
      data_out  = data_in;
      exc_out   = exc_in;
      ecode_out = ecode_in;
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue with a reference queue model as scoreboard.
// Expected head entries are queued on accepted pushes and compared on each cycle.
module tb_inst_queue;

  localparam int DEPTH   = 4;
  localparam int DATA_W  = 64;
  localparam int ECODE_W = 6;

  logic               aclk = 1'b0;
  logic               aresetn;
  logic               valid_in;
  logic [DATA_W-1:0]  data_in;
  logic               exc_in;
  logic [ECODE_W-1:0] ecode_in;
  logic               allow_out;
  logic               valid_out;
  logic [DATA_W-1:0]  data_out;
  logic               exc_out;
  logic [ECODE_W-1:0] ecode_out;
  logic               allow_in;
  logic [DATA_W-1:0]  nop_data;
  logic               flush;
  logic [2:0]         count;

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic               exc;
    logic [ECODE_W-1:0] ecode;
  } ent_t;

  ent_t q[$];
  logic m_lock;
  int   tests = 0;
  int   fails = 0;

  always #5 aclk = ~aclk;

  inst_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ECODE_W(ECODE_W)) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .exc_in    (exc_in),
    .ecode_in  (ecode_in),
    .allow_out (allow_out),
    .valid_out (valid_out),
    .data_out  (data_out),
    .exc_out   (exc_out),
    .ecode_out (ecode_out),
    .allow_in  (allow_in),
    .nop_data  (nop_data),
    .flush     (flush),
    .count     (count)
  );

  function automatic logic [63:0] mk(input logic [31:0] pc);
    return {pc, ~pc};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic e,
                       input logic [5:0] ec, input logic ain, input logic fl);
    valid_in = v;
    data_in  = mk(pc);
    exc_in   = e;
    ecode_in = ec;
    allow_in = ain;
    flush    = fl;
  endtask

  // Check outputs against the model for the current inputs, clock once, update model.
  task automatic cyc(input string tag);
    logic exp_byp, exp_allow, exp_valid, push, pop;
    ent_t exp_head;
    #1;
    exp_byp = 1'b0;
`ifdef INST_QUEUE_BYPASS_EN
    exp_byp = (q.size() == 0) && valid_in && !m_lock;
`endif
    exp_allow = (q.size() != DEPTH) && !m_lock;
    exp_valid = (q.size() != 0) || exp_byp;
    if (q.size() != 0)  exp_head = q[0];
    else if (exp_byp)   exp_head = '{data: data_in, exc: exc_in, ecode: ecode_in};
    else                exp_head = '{data: nop_data, exc: 1'b0, ecode: '0};
    check($sformatf("%s.allow_out", tag), 64'(allow_out), 64'(exp_allow));
    check($sformatf("%s.valid_out", tag), 64'(valid_out), 64'(exp_valid));
    check($sformatf("%s.count", tag), 64'(count), 64'(q.size()));
    check($sformatf("%s.data_out", tag), data_out, exp_head.data);
    check($sformatf("%s.exc_out", tag), 64'(exc_out), 64'(exp_head.exc));
    check($sformatf("%s.ecode_out", tag), 64'(ecode_out), 64'(exp_head.ecode));
    push = valid_in && exp_allow;
    pop  = exp_valid && allow_in;
    @(posedge aclk);
    #1;
    if (flush) begin
      q.delete();
      m_lock = 1'b0;
    end else begin
      if (pop && q.size() != 0) void'(q.pop_front());
      if (push && !(exp_byp && allow_in))
        q.push_back('{data: mk(data_in[63:32]), exc: exc_in, ecode: ecode_in});
      if (push && exc_in) m_lock = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    nop_data = 64'h0000_0013_0000_0013;
    m_lock   = 1'b0;
    aresetn  = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 6'h0, 1'b0, 1'b0);
    #1;
    check("rst.valid_out", 64'(valid_out), 64'd0);
    check("rst.allow_out", 64'(allow_out), 64'd1);
    check("rst.count", 64'(count), 64'd0);
    check("rst.data_out", data_out, nop_data);
    check("rst.exc_out", 64'(exc_out), 64'd0);
    check("rst.ecode_out", 64'(ecode_out), 64'd0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;

    // Fill with ID stalled: fifth offer must be refused.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h1000 + 32'(4 * i), 1'b0, 6'h0, 1'b0, 1'b0);
      cyc($sformatf("fill%0d", i));
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 32'h0, 1'b0, 6'h0, 1'b1, 1'b0);
      cyc($sformatf("drain%0d", i));
    end

    // Streaming at occupancy 2.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h5000 + 32'(4 * i), 1'b0, 6'h0, 1'b0, 1'b0);
      cyc($sformatf("sprime%0d", i));
    end
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 32'h5008 + 32'(4 * i), 1'b0, 6'h0, 1'b1, 1'b0);
      cyc($sformatf("stream%0d", i));
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0, 1'b0, 6'h0, 1'b1, 1'b0);
      cyc($sformatf("sdrain%0d", i));
    end

    // Exception lock.
    drive(1'b1, 32'h2000, 1'b0, 6'h00, 1'b0, 1'b0); cyc("exc_push0");
    drive(1'b1, 32'h2004, 1'b1, 6'h08, 1'b0, 1'b0); cyc("exc_push1");
    drive(1'b1, 32'h2008, 1'b0, 6'h00, 1'b0, 1'b0); cyc("exc_offer0");
    cyc("exc_offer1");
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0, 1'b0, 6'h0, 1'b1, 1'b0);
      cyc($sformatf("exc_drain%0d", i));
    end
    drive(1'b0, 32'h0, 1'b0, 6'h0, 1'b0, 1'b1); cyc("exc_flush");
    drive(1'b0, 32'h0, 1'b0, 6'h0, 1'b0, 1'b0); cyc("exc_after");

    // Flush colliding with push and pop at occupancy 3, then held flush.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h4000 + 32'(4 * i), 1'b0, 6'h0, 1'b0, 1'b0);
      cyc($sformatf("fc_fill%0d", i));
    end
    drive(1'b1, 32'h4100, 1'b0, 6'h0, 1'b1, 1'b1); cyc("fc_collide");
    drive(1'b0, 32'h0, 1'b0, 6'h0, 1'b1, 1'b0);    cyc("fc_after");
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h4200 + 32'(4 * i), 1'b0, 6'h0, 1'b0, 1'b1);
      cyc($sformatf("fc_hold%0d", i));
    end
    drive(1'b0, 32'h0, 1'b0, 6'h0, 1'b0, 1'b0); cyc("fc_release");

    // Async reset mid-cycle with two entries and the lock set.
    drive(1'b1, 32'h6000, 1'b0, 6'h00, 1'b0, 1'b0); cyc("ar_push0");
    drive(1'b1, 32'h6004, 1'b1, 6'h11, 1'b0, 1'b0); cyc("ar_push1");
    drive(1'b0, 32'h0, 1'b0, 6'h0, 1'b0, 1'b0);
    #2;
    aresetn = 1'b0;
    #1;
    check("ar.valid_out", 64'(valid_out), 64'd0);
    check("ar.count", 64'(count), 64'd0);
    check("ar.allow_out", 64'(allow_out), 64'd1);
    check("ar.data_out", data_out, nop_data);
    q.delete();
    m_lock = 1'b0;
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    cyc("ar_after");

    // Empty queue, producer and consumer both ready.
    drive(1'b1, 32'h3000, 1'b0, 6'h0, 1'b1, 1'b0); cyc("byp0");
    drive(1'b0, 32'h0, 1'b0, 6'h0, 1'b1, 1'b0);    cyc("byp1");
    cyc("byp2");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
